// File: rtl/mips_mult_div_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states,
// latched control flags and a small conditional-negate helper.
package mips_mult_div_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_CALC = 2'd1,
    MDU_ST_FIX  = 2'd2
  } mdu_state_e;

  typedef struct packed {
    logic is_div;   // divide (1) or multiply (0)
    logic neg_res;  // negate product / quotient
    logic neg_rem;  // negate remainder (dividend was negative)
    logic div0;     // divisor was zero
  } mdu_ctl_t;

  function automatic logic [XLEN-1:0] mdu_cond_neg(input logic [XLEN-1:0] v,
                                                   input logic neg);
    return neg ? XLEN'(~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mips_mdu_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module mips_mdu_div_step
  import mips_mult_div_unit_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] diff;

  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign fits    = (shifted >= {1'b0, divisor_i});
  // When the divisor fits the difference is below the divisor, so 32 bits suffice
  assign diff    = shifted[XLEN-1:0] - divisor_i;
  assign rem_o   = fits ? diff : shifted[XLEN-1:0];
  assign quo_o   = {quo_i[XLEN-2:0], fits};

endmodule

// File: rtl/mips_mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Optional MDU_FAST_MULT_EN: single-cycle multiplier, multiplies skip CALC.
module mips_mult_div_unit
  import mips_mult_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_x,
  input  logic [XLEN-1:0] req_y,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  mdu_ctl_t          ctl_q, ctl_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d, busy_q, busy_d;

  logic              accept, op_mul, op_div, op_signed, start_iter;
  logic              sign_x, sign_y;
  logic [XLEN-1:0]   mag_x, mag_y;
  logic [XLEN-1:0]   div_rem, div_quo;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign accept    = req_valid & ~busy_q;
  assign op_mul    = (req_op == MDU_MULT) | (req_op == MDU_MULTU);
  assign op_div    = (req_op == MDU_DIV)  | (req_op == MDU_DIVU);
  assign op_signed = (req_op == MDU_MULT) | (req_op == MDU_DIV);
  assign sign_x    = op_signed & req_x[XLEN-1];
  assign sign_y    = op_signed & req_y[XLEN-1];
  assign mag_x     = mdu_cond_neg(req_x, sign_x);
  assign mag_y     = mdu_cond_neg(req_y, sign_y);

`ifdef MDU_FAST_MULT_EN
  logic [2*XLEN-1:0] fast_mag, fast_prod;
  assign fast_mag   = (2*XLEN)'(mag_x) * (2*XLEN)'(mag_y);
  assign fast_prod  = (sign_x ^ sign_y) ? (2*XLEN)'(~fast_mag + 1'b1) : fast_mag;
  assign start_iter = op_div;
`else
  assign start_iter = op_div | op_mul;
`endif

  // Radix-2 shift-add: low half holds the remaining multiplier bits
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  mips_mdu_div_step u_div_step (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .quo_i     (acc_q[XLEN-1:0]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  // Sign fix-up; divide-by-zero forces an all-ones quotient
  assign quo_fix  = ctl_q.div0 ? '1 : mdu_cond_neg(acc_q[XLEN-1:0], ctl_q.neg_res);
  assign rem_fix  = mdu_cond_neg(acc_q[2*XLEN-1:XLEN], ctl_q.neg_rem);
  assign prod_fix = ctl_q.neg_res ? (2*XLEN)'(~acc_q + 1'b1) : acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= MDU_ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_ST_IDLE: if (accept && start_iter) state_d = MDU_ST_CALC;
      MDU_ST_CALC: begin
        if (flush)                        state_d = MDU_ST_IDLE;
        else if (cnt_q == CNT_W'(1))      state_d = MDU_ST_FIX;
      end
      MDU_ST_FIX:  state_d = MDU_ST_IDLE;
      default:     state_d = MDU_ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    ctl_d  = ctl_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    busy_d = (state_d != MDU_ST_IDLE);
    case (state_q)
      MDU_ST_IDLE: begin
        if (accept) begin
          if (req_op == MDU_MTHI) hi_d = req_x;
          if (req_op == MDU_MTLO) lo_d = req_x;
          if (start_iter) begin
            cnt_d         = CNT_W'(XLEN);
            ctl_d.is_div  = op_div;
            ctl_d.neg_res = sign_x ^ sign_y;
            ctl_d.neg_rem = sign_x;
            ctl_d.div0    = op_div & (req_y == '0);
            // Divide keeps {rem, quo}; multiply keeps {partial, multiplier}
            acc_d         = op_div ? {{XLEN{1'b0}}, mag_x} : {{XLEN{1'b0}}, mag_y};
            opnd_d        = op_div ? mag_y : mag_x;
          end
`ifdef MDU_FAST_MULT_EN
          if (op_mul) begin
            {hi_d, lo_d} = fast_prod;
            done_d       = 1'b1;
          end
`endif
        end
      end
      MDU_ST_CALC: begin
        if (!flush) begin
          cnt_d = cnt_q - CNT_W'(1);
          acc_d = ctl_q.is_div ? {div_rem, div_quo} : mul_next;
        end
      end
      MDU_ST_FIX: begin
        if (!flush) begin
          if (ctl_q.is_div) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      ctl_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      ctl_q  <= ctl_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  assign req_ready = ~busy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mips_mult_div_unit.sv
// Directed + scoreboard bench for mips_mult_div_unit (default and MDU_FAST_MULT_EN builds).
module tb_mips_mult_div_unit;
  import mips_mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, flush;
  logic [2:0]  req_op;
  logic [31:0] req_x, req_y;
  logic        req_ready, busy, done;
  logic [31:0] hi, lo;

  mips_mult_div_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] h, input logic [31:0] l, input int lat);
    exp_t e;
    e.hi = h; e.lo = l; e.lat = lat;
    sb.push_back(e);
  endtask

  // Reference model built on 64-bit integer arithmetic
  task automatic push_model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x)); sy = longint'($signed(y));
    ux = longint'({32'd0, x}); uy = longint'({32'd0, y});
    case (op)
      MDU_MULT:  begin p = 64'(sx * sy); push_exp(p[63:32], p[31:0], MUL_LAT); end
      MDU_MULTU: begin p = 64'(ux * uy); push_exp(p[63:32], p[31:0], MUL_LAT); end
      default: begin
        if (y == 32'd0) push_exp(x, 32'hFFFF_FFFF, DIV_LAT);
        else begin
          if (op == MDU_DIV) begin q = sx / sy; r = sx % sy; end
          else               begin q = ux / uy; r = ux % uy; end
          push_exp(32'(r), 32'(q), DIV_LAT);
        end
      end
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input bit hold);
    req_op = op; req_x = x; req_y = y; req_valid = 1'b1;
    check("ready_before_issue", 64'(req_ready), 64'd1);
    tick;
    if (!hold) req_valid = 1'b0;
  endtask

  // Called in the first cycle after the accepting edge (cycle 1)
  task automatic wait_done(input string tag);
    exp_t e;
    int   cyc, busy_cnt;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    cyc = 1; busy_cnt = 0;
    while (!done && cyc < 60) begin
      if (busy) busy_cnt++;
      tick;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.lat - 1));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(e.hi));
    check({tag, "_lo"}, 64'(lo), 64'(e.lo));
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0;
    req_op = MDU_MTHI; req_x = '0; req_y = '0;
    tick; tick;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick;

    // Multiplies
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    issue(MDU_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    wait_done("mult");
    push_exp(32'h0000_0001, 32'hFFFF_FFFE, MUL_LAT);
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    wait_done("multu");

    // Divides
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done("div_neg7_2");
    push_exp(32'd1, 32'd3, DIV_LAT);
    issue(MDU_DIVU, 32'd7, 32'd2, 1'b0);
    wait_done("divu_7_2");
    push_exp(32'd5, 32'hFFFF_FFFF, DIV_LAT);
    issue(MDU_DIV, 32'd5, 32'd0, 1'b0);
    wait_done("div_by_zero");
    push_exp(32'd0, 32'h8000_0000, DIV_LAT);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("div_overflow");

    // Back-to-back MTHI/MTLO, then DIVU
    issue(MDU_MTHI, 32'h1234, 32'd0, 1'b1);
    check("mthi_busy", 64'(busy), 64'd0);
    req_op = MDU_MTLO; req_x = 32'h5678;
    tick;
    req_valid = 1'b0;
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mtlo_lo", 64'(lo), 64'h5678);
    push_exp(32'd2, 32'd14, DIV_LAT);
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    wait_done("divu_100_7");

    // Flush mid-op; a request alongside the flush is refused, the next one is taken
    issue(MDU_MTHI, 32'h1, 32'd0, 1'b0);
    issue(MDU_MTLO, 32'h2, 32'd0, 1'b0);
    issue(MDU_DIVU, 32'd9, 32'd3, 1'b0);
    repeat (9) tick;
    flush = 1'b1; req_op = MDU_DIVU; req_x = 32'd100; req_y = 32'd7; req_valid = 1'b1;
    tick;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_hi", 64'(hi), 64'h1);
    check("flush_lo", 64'(lo), 64'h2);
    push_exp(32'd2, 32'd14, DIV_LAT);
    tick;
    req_valid = 1'b0;
    check("post_flush_accept_busy", 64'(busy), 64'd1);
    wait_done("post_flush_divu");

    // Flush while idle does not block acceptance
    push_model(MDU_MULTU, 32'h0001_0003, 32'h0002_0005);
    flush = 1'b1;
    issue(MDU_MULTU, 32'h0001_0003, 32'h0002_0005, 1'b0);
    flush = 1'b0;
    wait_done("idle_flush_multu");

    // Request held during busy is ignored until the done cycle
    push_model(MDU_DIV, 32'd100, 32'hFFFF_FFF9);
    issue(MDU_DIV, 32'd100, 32'hFFFF_FFF9, 1'b1);
    req_op = MDU_MTLO; req_x = 32'hAA;
    wait_done("div_held_req");
    tick;
    req_valid = 1'b0;
    check("held_mtlo_lo", 64'(lo), 64'hAA);
    check("held_mtlo_hi", 64'(hi), 64'd2);

    // Random operations against the model
    for (int i = 0; i < 6; i++) begin
      logic [2:0]  op;
      logic [31:0] x, y;
      op = 3'($urandom_range(0, 3));
      x  = $urandom;
      y  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 3 == 2) x = -x;
      push_model(op, x, y);
      issue(op, x, y, 1'b0);
      wait_done("random_op");
    end

    // Reset in the middle of a divide
    issue(MDU_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (19) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("midop_rst_hi", 64'(hi), 64'd0);
    check("midop_rst_lo", 64'(lo), 64'd0);
    check("midop_rst_busy", 64'(busy), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      tick;
    end
    check("midop_rst_no_done", 64'(done_seen), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
